// File: rtl/serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_alu_ctrl
// Summary  : Bit-serial sequencer that steps an external 1-bit ALU cell LSB
//            first to compute WIDTH-bit ADD/SUB/AND/OR/XOR/NOT.
//            Optional macro SERIAL_ALU_OVF_EN adds a signed-overflow output.
// Revision : 1.0  initial release
// ============================================================================
module serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_cin,
    output logic [1:0]       cell_s,
    output logic             cell_l,
`ifdef SERIAL_ALU_OVF_EN
    output logic             ovf,
`endif
    input  logic             cell_out,
    input  logic             cell_cout
);

    localparam int               c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2:0]           r_op;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_carry;
    logic [WIDTH-1:0]     r_result;
    logic                 r_carry_out;
    logic                 r_zero;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_sub;
    logic [WIDTH-1:0]     w_next_result;

    assign w_sub         = r_op[2] & r_op[0];
    assign w_next_result = {cell_out, r_result[WIDTH-1:1]};
    assign result        = r_result;
    assign carry_out     = r_carry_out;
    assign zero          = r_zero;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        cell_a      = 1'b0;
        cell_b      = 1'b0;
        cell_cin    = 1'b0;
        cell_s      = 2'b00;
        cell_l      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                cell_a   = r_a[0];
                cell_b   = r_b[0] ^ w_sub;
                cell_cin = r_op[2] & r_carry;
                cell_s   = r_op[1:0];
                cell_l   = r_op[2];
                if (r_cnt == c_LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                // Back-to-back: a start seen here launches the next op directly
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_cnt   <= '0;
            // SUB is A + ~B + 1: the +1 enters as the initial carry
            r_carry <= op[2] & op[0];
        end else if (busy) begin
            r_a      <= r_a >> 1;
            r_b      <= r_b >> 1;
            r_cnt    <= r_cnt + 1'b1;
            r_result <= w_next_result;
            if (r_op[2]) begin
                r_carry <= cell_cout;
            end
            if (w_last) begin
                r_carry_out <= r_op[2] & cell_cout;
                r_zero      <= (w_next_result == '0);
            end
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    logic r_ovf;
    assign ovf = r_ovf;

    // Signed overflow: carry into the MSB differs from carry out of it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_op[2] & (r_carry ^ cell_cout);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_alu_ctrl
// Summary  : Self-checking bench for serial_alu_ctrl with a behavioural
//            1-bit cell and an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_alu_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
    logic       cell_a;
    logic       cell_b;
    logic       cell_cin;
    logic [1:0] cell_s;
    logic       cell_l;
    logic       cell_out;
    logic       cell_cout;
`ifdef SERIAL_ALU_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_alu_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .cell_a    (cell_a),
        .cell_b    (cell_b),
        .cell_cin  (cell_cin),
        .cell_s    (cell_s),
        .cell_l    (cell_l),
`ifdef SERIAL_ALU_OVF_EN
        .ovf       (ovf),
`endif
        .cell_out  (cell_out),
        .cell_cout (cell_cout)
    );

    // External 1-bit ALU cell: logic unit, full adder, output mux
    logic w_logic;
    always_comb begin
        w_logic = 1'b0;
        case (cell_s)
            2'b00: w_logic = cell_a & cell_b;
            2'b01: w_logic = cell_a | cell_b;
            2'b10: w_logic = cell_a ^ cell_b;
            2'b11: w_logic = ~cell_a;
            default: w_logic = 1'b0;
        endcase
    end
    assign cell_out  = cell_l ? (cell_a ^ cell_b ^ cell_cin) : w_logic;
    assign cell_cout = (cell_a & cell_b) | (cell_a & cell_cin) | (cell_b & cell_cin);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: returns {ovf, carry, result}
    function automatic logic [9:0] ref_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [8:0] s;
        int         exact;
        logic       v;
        s = 9'd0;
        v = 1'b0;
        if (o[2]) begin
            if (o[0]) begin
                s     = {1'b0, x} + {1'b0, ~y} + 9'd1;
                exact = int'($signed(x)) - int'($signed(y));
            end else begin
                s     = {1'b0, x} + {1'b0, y};
                exact = int'($signed(x)) + int'($signed(y));
            end
            v = (exact > 127) || (exact < -128);
        end else begin
            case (o[1:0])
                2'b00: s = {1'b0, x & y};
                2'b01: s = {1'b0, x | y};
                2'b10: s = {1'b0, x ^ y};
                default: s = {1'b0, ~x};
            endcase
        end
        return {v, s};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic [9:0] e);
        check("result", 32'(result), 32'(e[7:0]));
        check("carry_out", 32'(carry_out), 32'(e[8]));
        check("zero", 32'(zero), 32'(e[7:0] == 8'h00));
`ifdef SERIAL_ALU_OVF_EN
        check("ovf", 32'(ovf), 32'(e[9]));
`endif
    endtask

    task automatic run_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input bit poke);
        logic [9:0] e;
        int         n;
        int         k;
        bit         cin_bad;
        e = ref_op(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        n = 0; k = 0; cin_bad = 1'b0;
        while (done !== 1'b1 && k < 20) begin
            if (busy === 1'b1) n++;
            if (!o[2] && cell_cin !== 1'b0) cin_bad = 1'b1;
            start = poke && (n == 3);
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done", 32'(done), 32'd1);
        check("busy_cycles", 32'(n), 32'd8);
        check("busy_in_done", 32'(busy), 32'd0);
        if (!o[2]) check("cell_cin_logic", 32'(cin_bad), 32'd0);
        check_outputs(e);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("result_held", 32'(result), 32'(e[7:0]));
    endtask

    initial begin
        logic [9:0] e1;
        int         k;
        bit         saw_done;

        reset = 1'b1; start = 1'b0; op = 3'd0; a = 8'd0; b = 8'd0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_cell", 32'({cell_a, cell_b, cell_cin, cell_s, cell_l}), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed operations
        run_op(3'b100, 8'h3C, 8'h0F, 1'b0);
        run_op(3'b100, 8'hFF, 8'h01, 1'b0);
        run_op(3'b100, 8'h7F, 8'h01, 1'b0);
        run_op(3'b101, 8'h05, 8'h07, 1'b0);
        run_op(3'b101, 8'h07, 8'h05, 1'b1);
        run_op(3'b000, 8'hCA, 8'h0F, 1'b0);
        run_op(3'b001, 8'hCA, 8'h0F, 1'b1);
        run_op(3'b010, 8'hCA, 8'h0F, 1'b0);
        run_op(3'b011, 8'hCA, 8'h0F, 1'b0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 8'h3C; b = 8'h0F;
        k = 0;
        while (done !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("b2b_done1", 32'(done), 32'd1);
        check("b2b_result1", 32'(result), 32'h4B);
        op = 3'b101; a = 8'h07; b = 8'h05;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done !== 1'b1 && k < 30);
        start = 1'b0;
        check("b2b_spacing", 32'(k), 32'd9);
        check("b2b_result2", 32'(result), 32'h02);
        check("b2b_carry2", 32'(carry_out), 32'd1);
        @(negedge clk);

        // Reset during RUN cycle 4
        @(negedge clk);
        start = 1'b1; op = 3'b100; a = 8'h3C; b = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        saw_done = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        check("no_done_after_rst", 32'(saw_done), 32'd0);
        run_op(3'b100, 8'h3C, 8'h0F, 1'b0);

        // Randomized operations
        repeat (30) begin
            logic [2:0] ro;
            logic [7:0] ra;
            logic [7:0] rb;
            ro = 3'($urandom);
            ra = 8'($urandom);
            rb = 8'($urandom);
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
        end

        e1 = ref_op(3'b100, 8'h00, 8'h00);
        run_op(3'b100, 8'h00, 8'h00, 1'b0);
        check("zero_add", 32'(zero), 32'(e1[7:0] == 8'h00));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
